sump_tx: RTL and testbench
==========================

# sump_tx

Transmit half of the logIP host link: it serializes captured sample words onto the UART TX line toward the host. Each accepted 32-bit word is sent as up to four 8N1 bytes, LSB byte first, and bytes whose group is disabled in the mask are skipped. The block sits between the logIP sample readout and `uart_tx_o` of the demo top, and runs on the system clock.

## Interface
- `CLK_PER_BIT`, default 868: system clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `WIDTH`, default 32: sample word width. Must be a multiple of 8.
- `clk_i`, input, 1: system clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `data_i`, input, WIDTH: sample word.
- `mask_i`, input, WIDTH/8: byte enables. Bit n=1 means byte n (`data_i[8n+7:8n]`) is sent.
- `stb_i`, input, 1: word valid.
- `rdy_o`, output, 1: ready to accept a word. A word is accepted when `stb_i && rdy_o`.
- `busy_o`, output, 1: a frame is in progress.
- `tx_o`, output, 1: serial line. Idles high.

## Operation
- Reset values: `tx_o`=1, `rdy_o`=1, `busy_o`=0, FSM=IDLE, all counters 0.
- On accept, `data_i` and `mask_i` are captured into internal registers. Inputs are not sampled again until the next accept.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE, accept with nonzero mask: load the byte index with the lowest set mask bit, then go to START.
  - IDLE, accept with mask == 0: the word is consumed, nothing is sent, and the FSM stays in IDLE (`rdy_o` remains 1).
  - START: `tx_o`=0 for one bit time, then go to DATA.
  - DATA: send 8 bits LSB first, one bit time each, then go to STOP.
  - STOP: `tx_o`=1 for one bit time. Then, if a higher enabled byte remains, load its index and go to START; otherwise go to IDLE.
- Each frame is 10 bit times (10×`CLK_PER_BIT` cycles).
- Consecutive enabled bytes are sent with no idle gap between the stop bit and the next start bit.
- Disabled bytes are skipped with no time cost.
- `rdy_o` = 1 only in IDLE. `busy_o` = !`rdy_o`.
- `stb_i` while `rdy_o`=0 is ignored. The source must hold the word until accepted.
- The bit-time counter counts 0..`CLK_PER_BIT`-1 and wraps to 0 at each bit boundary. Counter width is $clog2(`CLK_PER_BIT`).
- The bit counter is 3 bits. The byte index is $clog2(WIDTH/8) bits; use at least 1 bit.
- `tx_o` is driven directly from a flop, so the line is glitch-free.

## Timing
- Accept at edge k: from edge k+1, `tx_o`=0 (start bit), `rdy_o`=0 and `busy_o`=1.
- Data bit i of the first byte is driven from edge k+1+(1+i)×`CLK_PER_BIT`.
- The stop bit of the final byte ends at edge k+1+10·N·`CLK_PER_BIT`, where N = popcount(mask).
  - At that edge, `rdy_o` returns to 1 and `tx_o` stays 1.
  - A new accept is possible in that same cycle, so back-to-back words also have no gap.
- Mask-zero accept: `rdy_o` never drops and `tx_o` never changes.
- `rst_i` asserted mid-frame: at the next edge, `tx_o`=1, `rdy_o`=1, `busy_o`=0 and the FSM is in IDLE. The partial frame is truncated and the captured word is discarded.
- `rst_i` has priority over a simultaneous `stb_i`; the word is not accepted.

## Test plan
All scenarios use `CLK_PER_BIT`=4 and `WIDTH`=32.
- Reset: hold `rst_i` for 3 cycles -> `tx_o`=1, `rdy_o`=1, `busy_o`=0; `tx_o` stays 1 for 100 idle cycles.
- Single word: `data_i`=0x44332211, `mask_i`=0xF -> line decodes bytes 0x11, 0x22, 0x33, 0x44 in order; 160 cycles with no gaps; `rdy_o` returns to 1 exactly 161 cycles after accept.
- Sparse mask: `data_i`=0xA5C3_0F55, `mask_i`=0b1010 -> bytes 0x0F then 0xA5 are sent, 80 cycles total.
- Zero mask followed by a word:
  - Accept with `mask_i`=0 -> `rdy_o` stays 1 and `tx_o` stays 1.
  - Next cycle, accept 0x000000FF with `mask_i`=0x1 -> a single frame carrying 0xFF.
- Backpressure and back-to-back words:
  - Hold `stb_i`=1 continuously with a changing `data_i` -> only the word present at each accept is sent.
  - Two words with `mask_i`=0x1 -> 2 contiguous frames, with the second start bit directly after the first stop bit.
- Reset mid-frame: assert `rst_i` during bit 3 of byte 1 -> next edge `tx_o`=1, `rdy_o`=1; a following word 0x5A with `mask_i`=0x1 transmits correctly.

Source files
------------

// File: rtl/sump_tx.sv
// sump_tx: serializes captured sample words onto an 8N1 UART line, LSB byte first, skipping masked-off bytes.
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   data_i : sample word, captured on accept
//   mask_i : byte enables, bit n sends data_i[8n+7:8n]
//   stb_i  : word valid; accepted when stb_i && rdy_o
//   rdy_o  : high only while idle
//   busy_o : frame in progress (!rdy_o)
//   tx_o   : registered serial line, idles high
module sump_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [WIDTH/8-1:0] mask_i,
    input  logic               stb_i,
    output logic               rdy_o,
    output logic               busy_o,
    output logic               tx_o
);
    localparam int NB = WIDTH / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam int CW = $clog2(CLK_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2:0]         bit_idx, bit_n;
    logic [BW-1:0]      byte_idx, byte_n;
    logic [NB-1:0]      mask_r, mask_n, rem;
    logic [NB-1:0][7:0] data_r, data_n;
    logic               tick, acc, tx_n;
    function automatic logic [BW-1:0] lowest(input logic [NB-1:0] m);
        lowest = '0;
        for (int i = NB - 1; i >= 0; i--)
            if (m[i]) lowest = BW'(i);
    endfunction
    assign rdy_o  = state == IDLE;
    assign busy_o = !rdy_o;
    always_comb begin
        tick    = cnt == CW'(CLK_PER_BIT - 1);
        acc     = stb_i && rdy_o;
        // bytes still pending once the current one finishes
        rem     = mask_r & ~(NB'(1) << byte_idx);
        state_n = state;
        cnt_n   = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        bit_n   = state == DATA ? bit_idx + 3'(tick) : 3'd0;
        byte_n  = byte_idx;
        mask_n  = mask_r;
        data_n  = data_r;
        case (state)
            IDLE: if (acc) begin
                data_n  = data_i;
                mask_n  = mask_i;
                byte_n  = lowest(mask_i);
                state_n = |mask_i ? START : IDLE;
            end
            START: if (tick) state_n = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_n = STOP;
            STOP:  if (tick) begin
                mask_n  = rem;
                byte_n  = lowest(rem);
                state_n = |rem ? START : IDLE;
            end
        endcase
        // line level follows the state being entered so tx_o can come straight from a flop
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? data_n[byte_n][bit_n] : 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            mask_r   <= '0;
            data_r   <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            mask_r   <= mask_n;
            data_r   <= data_n;
            tx_o     <= tx_n;
        end
    end
endmodule

// File: tb/tb_sump_tx.sv
// tb_sump_tx: randomized and directed stimulus for sump_tx against a line-waveform reference model.
module tb_sump_tx;
    localparam int CPB = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic [3:0]  mask = '0;
    logic        stb = 1'b0;
    logic        rdy, busy, tx;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    bit          m_acc = 1'b0;
    bit          m_idle;
    int          q[$];

    sump_tx #(.CLK_PER_BIT(CPB), .WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .mask_i(mask),
        .stb_i(stb), .rdy_o(rdy), .busy_o(busy), .tx_o(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference: an accepted word becomes the full list of per-cycle line levels it must produce;
    // the link is ready exactly when that list has been played out.
    always @(posedge clk) begin
        m_idle = q.size() == 0;
        m_acc  = 1'b0;
        if (rst) q.delete();
        else begin
            if (q.size() != 0) void'(q.pop_front());
            if (m_idle && stb) begin
                m_acc = 1'b1;
                for (int n = 0; n < 4; n++)
                    if (mask[n])
                        for (int b = 0; b < 10; b++)
                            repeat (CPB) q.push_back(b == 0 ? 0 : b == 9 ? 1 : int'(data[8*n+b-1]));
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("tx", 32'(tx), q.size() != 0 ? 32'(q[0]) : 32'd1);
        chk("rdy", 32'(rdy), 32'(q.size() == 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
    end

    // call at a negedge; returns at the negedge following the accepting edge
    task automatic send(input logic [31:0] d, input logic [3:0] m);
        stb = 1'b1; data = d; mask = m;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_acc) break;
        end
        chk("accept_timeout", 32'(m_acc), 32'd1);
        stb = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_rdy", 32'(rdy), 32'd1);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        send(32'h44332211, 4'hF);
        repeat (159) @(negedge clk);
        chk("single_busy_end", 32'(rdy), 32'd0);
        @(negedge clk);
        chk("single_rdy_161", 32'(rdy), 32'd1);
        send(32'hA5C30F55, 4'b1010);
        wait_idle();
        send(32'h12345678, 4'h0);
        send(32'h000000FF, 4'h1);
        wait_idle();
        send(32'h000000C3, 4'h1);
        send(32'h0000003C, 4'h1);
        wait_idle();
        stb = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data = $urandom;
            mask = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        stb = 1'b0;
        wait_idle();
        send(32'h44332211, 4'hF);
        repeat (57) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_rdy", 32'(rdy), 32'd1);
        send(32'h0000005A, 4'h1);
        wait_idle();
        for (int w = 0; w < 25; w++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom, 4'($urandom_range(0, 15)));
        end
        wait_idle();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
